// File: rtl/jtframe_bank_arbiter.sv
// jtframe_bank_arbiter
// Round-robin arbiter that shares one SDRAM bank port between NCH game ROM
// channels. Each channel gets back its own data word and an ok flag. The ok
// flag means "ch_dout holds the word for the address you are driving now".
//
// Parameters: NCH channels (1..8), AW address width, DW data width.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   downloading       ROM download in progress: no new reads, all ok low
//   ch_req/ch_addr    per-channel level request and address (channel i at [i*AW +: AW])
//   ch_dout/ch_ok     per-channel data (channel i at [i*DW +: DW]) and valid flag
//   ba_addr/ba_rd     registered request to the SDRAM bank
//   ba_ack/ba_rdy     controller accept / read data strobe
//   sdram_dout        SDRAM read data
// Build option: define JTFRAME_ARB_CACHE_EN to add one extra cached line per
// channel. The line holds the word that the most recent fetch displaced, so a
// channel can flip between two addresses without touching the SDRAM.
module jtframe_bank_arbiter #(
  parameter int NCH = 4,
  parameter int AW  = 22,
  parameter int DW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_addr,
  output logic [NCH*DW-1:0] ch_dout,
  output logic [NCH-1:0]    ch_ok,
  output logic [AW-1:0]     ba_addr,
  output logic              ba_rd,
  input  logic              ba_ack,
  input  logic              ba_rdy,
  input  logic [DW-1:0]     sdram_dout
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t          state_q, state_d;
  logic            ba_rd_q, ba_rd_d;
  logic [AW-1:0]   ba_addr_q, ba_addr_d;
  logic [SW-1:0]   sel_q, sel_d, rr_q, rr_d;
  logic [NCH-1:0]  ok_q, ok_d, cur_v_q, cur_v_d;
  logic [AW-1:0]   tag_q [NCH];
  logic [AW-1:0]   tag_d [NCH];
  logic [DW-1:0]   dout_q [NCH];
  logic [DW-1:0]   dout_d [NCH];

  logic [AW-1:0]   addr_w [NCH];
  logic [NCH-1:0]  cur_hit, c_hit, cand, fill, fill_match;
  logic            take, found;
  logic [SW-1:0]   pick, pick_hi, pick_lo, rr_next;
  logic            found_hi;

`ifdef JTFRAME_ARB_CACHE_EN
  logic [AW-1:0]   ctag_q [NCH];
  logic [AW-1:0]   ctag_d [NCH];
  logic [DW-1:0]   cdata_q [NCH];
  logic [DW-1:0]   cdata_d [NCH];
  logic [NCH-1:0]  cv_q, cv_d;
  logic            dl_q;
  logic            dl_rise;
  assign dl_rise = downloading && !dl_q;
`endif

  // Read data is taken in WAIT_RDY, or in WAIT_ACK when ack and rdy coincide.
  assign take = ba_rdy && (state_q == WAIT_RDY || (state_q == WAIT_ACK && ba_ack));

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign addr_w[gi]              = ch_addr[gi*AW +: AW];
      assign ch_dout[gi*DW +: DW]    = dout_q[gi];
      assign cur_hit[gi]             = cur_v_q[gi] && (addr_w[gi] == tag_q[gi]);
      assign fill[gi]                = take && (sel_q == SW'(gi));
      assign fill_match[gi]          = addr_w[gi] == ba_addr_q;
`ifdef JTFRAME_ARB_CACHE_EN
      assign c_hit[gi]               = cv_q[gi] && (addr_w[gi] == ctag_q[gi]);
`else
      assign c_hit[gi]               = 1'b0;
`endif
      // A channel whose address moved away from its tag is eligible at once,
      // even though its registered ok only falls on the next clock.
      assign cand[gi]                = ch_req[gi] && !downloading && !cur_hit[gi] && !c_hit[gi];
    end
  endgenerate

  // Round-robin: take the lowest candidate at or above rr_q, else the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i] && i >= int'(rr_q)) begin
        found_hi = 1'b1;
        pick_hi  = SW'(i);
      end
      if (cand[i]) pick_lo = SW'(i);
    end
    found   = |cand;
    pick    = found_hi ? pick_hi : pick_lo;
    rr_next = (int'(pick) == NCH - 1) ? '0 : pick + SW'(1);
  end

  always_comb begin
    state_d   = state_q;
    ba_rd_d   = ba_rd_q;
    ba_addr_d = ba_addr_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ba_addr_d = addr_w[pick];
          ba_rd_d   = 1'b1;
          sel_d     = pick;
          rr_d      = rr_next;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          state_d = ba_rdy ? IDLE : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ba_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ok_d    = '0;
    cur_v_d = cur_v_q;
`ifdef JTFRAME_ARB_CACHE_EN
    cv_d    = cv_q;
`endif
    for (int i = 0; i < NCH; i++) begin
      tag_d[i]  = tag_q[i];
      dout_d[i] = dout_q[i];
`ifdef JTFRAME_ARB_CACHE_EN
      ctag_d[i]  = ctag_q[i];
      cdata_d[i] = cdata_q[i];
      if (fill[i]) begin
        // The displaced current line becomes the cached line.
        ctag_d[i]  = tag_q[i];
        cdata_d[i] = dout_q[i];
        cv_d[i]    = cur_v_q[i];
        tag_d[i]   = ba_addr_q;
        dout_d[i]  = sdram_dout;
        cur_v_d[i] = !downloading;
        ok_d[i]    = !downloading && ch_req[i] && fill_match[i];
      end else if (ch_req[i] && !downloading && c_hit[i] && !cur_hit[i]) begin
        // Swap lines so ch_dout presents the cached word.
        ctag_d[i]  = tag_q[i];
        cdata_d[i] = dout_q[i];
        cv_d[i]    = cur_v_q[i];
        tag_d[i]   = ctag_q[i];
        dout_d[i]  = cdata_q[i];
        cur_v_d[i] = 1'b1;
        ok_d[i]    = 1'b1;
      end else begin
        ok_d[i]    = !downloading && ch_req[i] && cur_hit[i];
      end
      if (dl_rise) begin
        cur_v_d[i] = 1'b0;
        cv_d[i]    = 1'b0;
      end
`else
      // Without a cache the valid bit is the ok flag itself, so leaving an
      // address forgets it for good.
      if (fill[i]) begin
        tag_d[i]   = ba_addr_q;
        dout_d[i]  = sdram_dout;
        cur_v_d[i] = !downloading && ch_req[i] && fill_match[i];
      end else begin
        cur_v_d[i] = !downloading && ch_req[i] && cur_hit[i];
      end
      ok_d[i] = cur_v_d[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ba_rd_q   <= 1'b0;
      ba_addr_q <= '0;
      sel_q     <= '0;
      rr_q      <= '0;
      ok_q      <= '0;
      cur_v_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        tag_q[i]  <= '0;
        dout_q[i] <= '0;
      end
`ifdef JTFRAME_ARB_CACHE_EN
      cv_q <= '0;
      dl_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ctag_q[i]  <= '0;
        cdata_q[i] <= '0;
      end
`endif
    end else begin
      state_q   <= state_d;
      ba_rd_q   <= ba_rd_d;
      ba_addr_q <= ba_addr_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      ok_q      <= ok_d;
      cur_v_q   <= cur_v_d;
      for (int i = 0; i < NCH; i++) begin
        tag_q[i]  <= tag_d[i];
        dout_q[i] <= dout_d[i];
      end
`ifdef JTFRAME_ARB_CACHE_EN
      cv_q <= cv_d;
      dl_q <= downloading;
      for (int i = 0; i < NCH; i++) begin
        ctag_q[i]  <= ctag_d[i];
        cdata_q[i] <= cdata_d[i];
      end
`endif
    end
  end

  assign ba_rd   = ba_rd_q;
  assign ba_addr = ba_addr_q;
  assign ch_ok   = ok_q;

endmodule
